// File: rtl/acl_rx_frame_arbiter.sv
// Frame-atomic round-robin arbiter merging N_PORTS rx streams onto one ACL ingress stream.
// Optional beat-count truncation with DRAIN state is enabled by defining ACL_ARB_TIMEOUT_EN.
module acl_rx_frame_arbiter #(
    parameter int N_PORTS   = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 380
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PORTS*DATA_W-1:0]   i_rx_data,
    input  logic [N_PORTS-1:0]          i_rxd_tvalid,
    input  logic [N_PORTS-1:0]          i_rx_tlast,
    output logic [N_PORTS-1:0]          o_rx_tready,
    output logic [DATA_W-1:0]           o_acl_data,
    output logic                        o_acl_tvalid,
    output logic                        o_acl_tlast,
    input  logic                        i_acl_tready,
    output logic [N_PORTS-1:0]          o_grant,
    output logic                        o_busy,
    output logic                        o_trunc
);

    localparam int IDX_W = $clog2(N_PORTS);

`ifdef ACL_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_DRAIN} state_t;
    localparam logic [15:0] LAST_CNT = 16'(MAX_BEATS - 1);
    logic [15:0] cnt_q, cnt_d;
    logic        trunc_q, trunc_d;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_GRANT} state_t;
    logic unused_max_beats;
    assign unused_max_beats = (MAX_BEATS > 0);
`endif

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [N_PORTS-1:0] grant_q, grant_d;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_valid;
    logic               sel_last;
    logic               xfer;

    assign sel_data  = i_rx_data[int'(gidx_q)*DATA_W +: DATA_W];
    assign sel_valid = i_rxd_tvalid[gidx_q];
    assign sel_last  = i_rx_tlast[gidx_q];

    // Round-robin scan starting one past the last owner.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 1; i <= N_PORTS; i++) begin
            int j;
            j = (int'(ptr_q) + i) % N_PORTS;
            if (!pick_vld && i_rxd_tvalid[j]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(j);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gidx_d       = gidx_q;
        grant_d      = grant_q;
        xfer         = 1'b0;
        o_rx_tready  = '0;
        o_acl_data   = '0;
        o_acl_tvalid = 1'b0;
        o_acl_tlast  = 1'b0;
`ifdef ACL_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        trunc_d      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    gidx_d           = pick_idx;
                    grant_d          = '0;
                    grant_d[pick_idx] = 1'b1;
                    state_d          = ST_GRANT;
`ifdef ACL_ARB_TIMEOUT_EN
                    cnt_d            = '0;
`endif
                end
            end
            ST_GRANT: begin
                o_acl_data   = sel_data;
                o_acl_tvalid = sel_valid;
                o_acl_tlast  = sel_last;
                o_rx_tready  = grant_q & {N_PORTS{i_acl_tready}};
                xfer         = sel_valid & i_acl_tready;
`ifdef ACL_ARB_TIMEOUT_EN
                if (cnt_q == LAST_CNT) o_acl_tlast = 1'b1;
                if (xfer) cnt_d = cnt_q + 16'd1;
                if (xfer && !sel_last && cnt_q == LAST_CNT) begin
                    state_d = ST_DRAIN;
                    trunc_d = 1'b1;
                end
`endif
                if (xfer && sel_last) begin
                    state_d = ST_IDLE;
                    ptr_d   = gidx_q;
                    grant_d = '0;
                end
            end
`ifdef ACL_ARB_TIMEOUT_EN
            // Discard the remainder of a truncated frame up to its own tlast.
            ST_DRAIN: begin
                o_rx_tready = grant_q;
                if (sel_valid && sel_last) begin
                    state_d = ST_IDLE;
                    ptr_d   = gidx_q;
                    grant_d = '0;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= IDX_W'(N_PORTS - 1);
            gidx_q  <= '0;
            grant_q <= '0;
`ifdef ACL_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            trunc_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            grant_q <= grant_d;
`ifdef ACL_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
`endif
        end
    end

    assign o_grant = grant_q;
    assign o_busy  = (state_q != ST_IDLE);
`ifdef ACL_ARB_TIMEOUT_EN
    assign o_trunc = trunc_q;
`else
    assign o_trunc = 1'b0;
`endif

endmodule

// File: tb/tb_acl_rx_frame_arbiter.sv
// Directed bench for acl_rx_frame_arbiter: 4 ports, 32-bit beats, MAX_BEATS=8.
module tb_acl_rx_frame_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*DW-1:0] rx_data = '0;
    logic [N-1:0]    rx_tvalid = '0;
    logic [N-1:0]    rx_tlast = '0;
    logic [N-1:0]    rx_tready;
    logic [DW-1:0]   acl_data;
    logic            acl_tvalid;
    logic            acl_tlast;
    logic            acl_tready = 1'b1;
    logic [N-1:0]    grant;
    logic            busy;
    logic            trunc;

    int checks = 0;
    int errors = 0;

    acl_rx_frame_arbiter #(.N_PORTS(N), .DATA_W(DW), .MAX_BEATS(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_rx_data    (rx_data),
        .i_rxd_tvalid (rx_tvalid),
        .i_rx_tlast   (rx_tlast),
        .o_rx_tready  (rx_tready),
        .o_acl_data   (acl_data),
        .o_acl_tvalid (acl_tvalid),
        .o_acl_tlast  (acl_tlast),
        .i_acl_tready (acl_tready),
        .o_grant      (grant),
        .o_busy       (busy),
        .o_trunc      (trunc)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic set_beat(input int p, input logic [31:0] d, input logic v, input logic l);
        rx_data[p*DW +: DW] = d;
        rx_tvalid[p] = v;
        rx_tlast[p]  = l;
    endtask

    task automatic clear_inputs();
        rx_data   = '0;
        rx_tvalid = '0;
        rx_tlast  = '0;
        acl_tready = 1'b1;
    endtask

    // Leaves the bench at a falling edge with the DUT idle and rst low.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_tvalid = '1;
        rx_tlast  = '1;
        rx_data   = '1;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (rx_tready !== 4'b0000) begin errors++; $display("FAIL reset_tready got %b want 0000", rx_tready); end
        checks++; if (acl_tvalid !== 1'b0 || acl_tlast !== 1'b0) begin errors++; $display("FAIL reset_acl_ctl got v=%b l=%b want 0 0", acl_tvalid, acl_tlast); end
        checks++; if (acl_data !== 32'h0) begin errors++; $display("FAIL reset_acl_data got %h want 0", acl_data); end
        checks++; if (trunc !== 1'b0) begin errors++; $display("FAIL reset_trunc got %b want 0", trunc); end
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_single_port();
        logic [31:0] beats [7];
        beats[0] = 32'h0014_2201; beats[1] = 32'h1111_0002; beats[2] = 32'h2222_0003;
        beats[3] = 32'h3333_0004; beats[4] = 32'h4444_0005; beats[5] = 32'h5555_0006;
        beats[6] = 32'h0800_DDDD;
        do_reset();
        set_beat(0, beats[0], 1'b1, 1'b0);
        #1;
        checks++; if (grant !== 4'b0000 || acl_tvalid !== 1'b0 || rx_tready !== 4'b0000) begin
            errors++; $display("FAIL single_arb_cycle got g=%b v=%b r=%b want 0000 0 0000", grant, acl_tvalid, rx_tready); end
        @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            set_beat(0, beats[k], 1'b1, k == 6);
            #1;
            checks++; if (grant !== 4'b0001 || rx_tready !== 4'b0001) begin
                errors++; $display("FAIL single_grant beat%0d got g=%b r=%b want 0001 0001", k, grant, rx_tready); end
            checks++; if (acl_data !== beats[k] || acl_tvalid !== 1'b1 || acl_tlast !== (k == 6)) begin
                errors++; $display("FAIL single_beat%0d got %h v=%b l=%b want %h 1 %b", k, acl_data, acl_tvalid, acl_tlast, beats[k], k == 6); end
            @(negedge clk);
        end
        set_beat(0, 32'h0, 1'b0, 1'b0);
        #1;
        checks++; if (grant !== 4'b0000 || busy !== 1'b0 || acl_tvalid !== 1'b0) begin
            errors++; $display("FAIL single_return_idle got g=%b b=%b v=%b want 0000 0 0", grant, busy, acl_tvalid); end
        @(negedge clk);
    endtask

    task automatic test_two_ports();
        do_reset();
        set_beat(0, 32'h0000_0A00, 1'b1, 1'b0);
        set_beat(2, 32'h0000_0C00, 1'b1, 1'b0);
        #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL two_arb_cycle got %b want 0000", grant); end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            set_beat(0, 32'h0000_0A00 + 32'(k), 1'b1, k == 2);
            #1;
            checks++; if (grant !== 4'b0001 || rx_tready !== 4'b0001 || acl_data !== 32'h0000_0A00 + 32'(k)) begin
                errors++; $display("FAIL two_p0_beat%0d got g=%b r=%b d=%h want 0001 0001 %h", k, grant, rx_tready, acl_data, 32'h0A00 + k); end
            @(negedge clk);
        end
        set_beat(0, 32'h0, 1'b0, 1'b0);
        #1;
        checks++; if (grant !== 4'b0000 || acl_tvalid !== 1'b0 || rx_tready !== 4'b0000) begin
            errors++; $display("FAIL two_idle_gap got g=%b v=%b r=%b want 0000 0 0000", grant, acl_tvalid, rx_tready); end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            set_beat(2, 32'h0000_0C00 + 32'(k), 1'b1, k == 1);
            #1;
            checks++; if (grant !== 4'b0100 || rx_tready !== 4'b0100 || acl_data !== 32'h0000_0C00 + 32'(k) || acl_tlast !== (k == 1)) begin
                errors++; $display("FAIL two_p2_beat%0d got g=%b r=%b d=%h l=%b want 0100 0100 %h %b", k, grant, rx_tready, acl_data, acl_tlast, 32'h0C00 + k, k == 1); end
            @(negedge clk);
        end
        clear_inputs();
        #1;
        checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL two_end_idle got g=%b b=%b want 0000 0", grant, busy); end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int bi [N];
        int started, done, exp_p;
        logic in_frame, just_ended;
        logic [N-1:0] acc;
        logic [31:0] exp_d;
        do_reset();
        for (int p = 0; p < N; p++) bi[p] = 0;
        started = 0; done = 0; exp_p = 0;
        in_frame = 1'b0; just_ended = 1'b0;
        for (int cyc = 0; cyc < 80 && done < 8; cyc++) begin
            for (int p = 0; p < N; p++)
                set_beat(p, 32'hA000_0000 | (32'(p) << 8) | 32'(bi[p]), 1'b1, bi[p] == 1);
            #1;
            if (just_ended) begin
                checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rr_gap frame%0d got %b want 0000", done, grant); end
                just_ended = 1'b0;
            end
            if (grant !== 4'b0000 && !in_frame) begin
                exp_p = started % N;
                checks++; if (grant !== 4'(1 << exp_p)) begin errors++; $display("FAIL rr_order frame%0d got %b want %b", started, grant, 4'(1 << exp_p)); end
                started++;
                in_frame = 1'b1;
            end
            if (in_frame) begin
                exp_d = 32'hA000_0000 | (32'(exp_p) << 8) | 32'(bi[exp_p]);
                checks++; if (acl_data !== exp_d) begin errors++; $display("FAIL rr_data frame%0d got %h want %h", started - 1, acl_data, exp_d); end
            end
            acc = rx_tready;
            @(posedge clk);
            for (int p = 0; p < N; p++) begin
                if (acc[p]) begin
                    if (bi[p] == 1) begin
                        bi[p] = 0; done++; in_frame = 1'b0; just_ended = 1'b1;
                    end else begin
                        bi[p] = 1;
                    end
                end
            end
            @(negedge clk);
        end
        checks++; if (done !== 8 || started !== 8) begin errors++; $display("FAIL rr_frames got done=%0d started=%0d want 8 8", done, started); end
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int k, rcv, stall;
        logic stalled, acc;
        do_reset();
        k = 0; rcv = 0; stall = 0;
        for (int cyc = 0; cyc < 30 && rcv < 6; cyc++) begin
            if (k < 6) set_beat(1, 32'hB000_0010 + 32'(k), 1'b1, k == 5);
            else       set_beat(1, 32'h0, 1'b0, 1'b0);
            if (k == 3 && stall < 3) begin acl_tready = 1'b0; stall++; stalled = 1'b1; end
            else begin acl_tready = 1'b1; stalled = 1'b0; end
            #1;
            if (stalled) begin
                checks++; if (acl_data !== 32'hB000_0013 || acl_tvalid !== 1'b1 || rx_tready !== 4'b0000 || grant !== 4'b0010) begin
                    errors++; $display("FAIL bp_hold got d=%h v=%b r=%b g=%b want b0000013 1 0000 0010", acl_data, acl_tvalid, rx_tready, grant); end
            end
            if (acl_tvalid && acl_tready) begin
                checks++; if (acl_data !== 32'hB000_0010 + 32'(rcv)) begin
                    errors++; $display("FAIL bp_seq beat%0d got %h want %h", rcv, acl_data, 32'hB000_0010 + rcv); end
                rcv++;
            end
            acc = rx_tready[1];
            @(posedge clk);
            if (acc) k++;
            @(negedge clk);
        end
        checks++; if (rcv !== 6 || k !== 6 || stall !== 3) begin errors++; $display("FAIL bp_count got rcv=%0d k=%0d stall=%0d want 6 6 3", rcv, k, stall); end
        clear_inputs();
        #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL bp_end_idle got %b want 0000", grant); end
        @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        do_reset();
        set_beat(1, 32'hC000_0000, 1'b1, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            set_beat(1, 32'hC000_0000 + 32'(k), 1'b1, 1'b0);
            #1;
            checks++; if (grant !== 4'b0010 || acl_data !== 32'hC000_0000 + 32'(k)) begin
                errors++; $display("FAIL rstmid_pre beat%0d got g=%b d=%h want 0010 %h", k, grant, acl_data, 32'hC000_0000 + k); end
            @(negedge clk);
        end
        set_beat(1, 32'hC000_0002, 1'b1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_beat(0, 32'hD000_0000, 1'b1, 1'b0);
        #1;
        checks++; if (grant !== 4'b0000 || busy !== 1'b0 || rx_tready !== 4'b0000) begin
            errors++; $display("FAIL rstmid_ctl got g=%b b=%b r=%b want 0000 0 0000", grant, busy, rx_tready); end
        checks++; if (acl_tvalid !== 1'b0 || acl_tlast !== 1'b0 || acl_data !== 32'h0 || trunc !== 1'b0) begin
            errors++; $display("FAIL rstmid_out got v=%b l=%b d=%h t=%b want 0 0 0 0", acl_tvalid, acl_tlast, acl_data, trunc); end
        @(negedge clk);
        #1;
        checks++; if (grant !== 4'b0001 || acl_data !== 32'hD000_0000) begin
            errors++; $display("FAIL rstmid_next got g=%b d=%h want 0001 d0000000", grant, acl_data); end
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_long_frame();
        int k, nout, ntl, tl_at, ntrunc, exp_out, exp_trunc;
        logic acc, fin;
`ifdef ACL_ARB_TIMEOUT_EN
        exp_out = 8;  exp_trunc = 1;
`else
        exp_out = 12; exp_trunc = 0;
`endif
        do_reset();
        k = 0; nout = 0; ntl = 0; tl_at = 0; ntrunc = 0; fin = 1'b0;
        for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
            if (k < 12) set_beat(3, 32'hE000_0000 + 32'(k), 1'b1, k == 11);
            else        set_beat(3, 32'h0, 1'b0, 1'b0);
            #1;
            if (k == 12 && !busy) fin = 1'b1;
            if (acl_tvalid && acl_tready) begin
                checks++; if (acl_data !== 32'hE000_0000 + 32'(nout)) begin
                    errors++; $display("FAIL long_data beat%0d got %h want %h", nout, acl_data, 32'hE000_0000 + nout); end
                nout++;
                if (acl_tlast) begin ntl++; tl_at = nout; end
            end
            if (trunc) ntrunc++;
            acc = rx_tready[3];
            @(posedge clk);
            if (acc && k < 12) k++;
            @(negedge clk);
        end
        checks++; if (nout !== exp_out) begin errors++; $display("FAIL long_out_beats got %0d want %0d", nout, exp_out); end
        checks++; if (ntl !== 1 || tl_at !== exp_out) begin errors++; $display("FAIL long_tlast got n=%0d at=%0d want 1 %0d", ntl, tl_at, exp_out); end
        checks++; if (ntrunc !== exp_trunc) begin errors++; $display("FAIL long_trunc got %0d want %0d", ntrunc, exp_trunc); end
        checks++; if (k !== 12 || fin !== 1'b1) begin errors++; $display("FAIL long_consumed got k=%0d idle=%b want 12 1", k, fin); end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_single_port();
        test_two_ports();
        test_round_robin();
        test_backpressure();
        test_reset_midframe();
        test_long_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
